// File: rtl/decimator_multich.sv
// Multi-channel decimator: run-time factor, pick (last sample) or boxcar sum per group.
// Optional build macro DECIM_SIGNED_EN selects two's-complement samples with sign extension.
module decimator_multich #(
    parameter int DATA_BW   = 8,
    parameter int NUM_CH    = 4,
    parameter int MAX_DECIM = 256,
    localparam int DECIM_BW = $clog2(MAX_DECIM + 1),
    localparam int SUM_BW   = DATA_BW + $clog2(MAX_DECIM)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       mode_i,
    input  logic [DECIM_BW-1:0]        decim_i,
    input  logic [NUM_CH*DATA_BW-1:0]  data_i,
    input  logic                       valid_i,
    output logic [NUM_CH*SUM_BW-1:0]   data_o,
    output logic                       valid_o,
    output logic                       busy_o
);

    function automatic logic [DECIM_BW-1:0] clamp_factor(input logic [DECIM_BW-1:0] d);
        logic [DECIM_BW-1:0] f;
        if (d <= DECIM_BW'(1)) begin
            f = DECIM_BW'(1);
        end else if (d > DECIM_BW'(MAX_DECIM)) begin
            f = DECIM_BW'(MAX_DECIM);
        end else begin
            f = d;
        end
        return f;
    endfunction

    function automatic logic [SUM_BW-1:0] ext_sample(input logic [DATA_BW-1:0] x);
`ifdef DECIM_SIGNED_EN
        return {{(SUM_BW-DATA_BW){x[DATA_BW-1]}}, x};
`else
        return {{(SUM_BW-DATA_BW){1'b0}}, x};
`endif
    endfunction

    logic [DECIM_BW-1:0]       cnt_q, cnt_d;
    logic [DECIM_BW-1:0]       factor_q, factor_d;
    logic                      mode_q, mode_d;
    logic [NUM_CH*SUM_BW-1:0]  acc_q, acc_d;
    logic [NUM_CH*SUM_BW-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;

    logic                      first_s;
    logic [DECIM_BW-1:0]       eff_factor_s;
    logic                      eff_mode_s;
    logic                      last_s;
    logic [NUM_CH*SUM_BW-1:0]  grp_sum_s;
    logic [NUM_CH*SUM_BW-1:0]  pick_s;

    // Group parameters: a new group takes the live inputs, an open group keeps its latched ones
    always_comb begin
        first_s      = (cnt_q == DECIM_BW'(0));
        eff_factor_s = factor_q;
        eff_mode_s   = mode_q;
        if (first_s) begin
            eff_factor_s = clamp_factor(decim_i);
            eff_mode_s   = mode_i;
        end else begin
            eff_factor_s = factor_q;
            eff_mode_s   = mode_q;
        end
        last_s = (cnt_q == (eff_factor_s - DECIM_BW'(1)));
    end

    // Per-channel running sum including the current sample, and the extended current sample
    always_comb begin
        grp_sum_s = '0;
        pick_s    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pick_s[c*SUM_BW +: SUM_BW] = ext_sample(data_i[c*DATA_BW +: DATA_BW]);
            if (first_s) begin
                grp_sum_s[c*SUM_BW +: SUM_BW] = pick_s[c*SUM_BW +: SUM_BW];
            end else begin
                grp_sum_s[c*SUM_BW +: SUM_BW] = acc_q[c*SUM_BW +: SUM_BW]
                                              + pick_s[c*SUM_BW +: SUM_BW];
            end
        end
    end

    // Next-state: disable discards the partial group, an accepted sample advances it
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        factor_d = factor_q;
        mode_d   = mode_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (!en_i) begin
            cnt_d = DECIM_BW'(0);
            acc_d = '0;
        end else if (valid_i) begin
            acc_d = grp_sum_s;
            if (first_s) begin
                factor_d = eff_factor_s;
                mode_d   = eff_mode_s;
            end else begin
                factor_d = factor_q;
                mode_d   = mode_q;
            end
            if (last_s) begin
                cnt_d   = DECIM_BW'(0);
                valid_d = 1'b1;
                data_d  = eff_mode_s ? grp_sum_s : pick_s;
            end else begin
                cnt_d   = cnt_q + DECIM_BW'(1);
                valid_d = 1'b0;
                data_d  = data_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        busy_d = (cnt_d != DECIM_BW'(0));
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= DECIM_BW'(0);
            acc_q    <= '0;
            factor_q <= DECIM_BW'(1);
            mode_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            factor_q <= factor_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule
